// File: rtl/gray_seek_ctrl.sv
// rtl/gray_seek_ctrl.sv - shortest-path seek controller driving a Gray-code ring position
// Steps the owned position one code per STEP state, with DWELL idle cycles between steps.
module gray_seek_ctrl #(
   parameter int WIDTH = 3,
   parameter int DWELL = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [WIDTH-1:0] target_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             step_o,
   output logic             dir_o,
   output logic [WIDTH-1:0] pos_gray_o,
   output logic [WIDTH-1:0] pos_bin_o
);

   localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CALC  = 3'd1,
      S_STEP  = 3'd2,
      S_DWELL = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pos_q, pos_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dir_q, dir_d;
   logic [DCW-1:0]   dwell_q, dwell_d;

   logic [WIDTH-1:0] dist_up, dist_dn, calc_rem;
   logic             calc_dir;

   // Modular distances wrap naturally in WIDTH bits; ties resolve upward.
   always_comb begin
      dist_up  = tgt_q - pos_q;
      dist_dn  = pos_q - tgt_q;
      calc_dir = (dist_up <= dist_dn);
      calc_rem = calc_dir ? dist_up : dist_dn;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         pos_q   <= '0;
         gray_q  <= '0;
         tgt_q   <= '0;
         rem_q   <= '0;
         dir_q   <= 1'b1;
         dwell_q <= '0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         gray_q  <= gray_d;
         tgt_q   <= tgt_d;
         rem_q   <= rem_d;
         dir_q   <= dir_d;
         dwell_q <= dwell_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_CALC;
         end
         S_CALC: begin
            if (abort_i)             state_d = S_IDLE;
            else if (calc_rem == '0) state_d = S_DONE;
            else                     state_d = S_STEP;
         end
         S_STEP: begin
            if (abort_i)                     state_d = S_IDLE;
            else if (rem_q == WIDTH'(1))     state_d = S_DONE;
            else if (DWELL == 0)             state_d = S_STEP;
            else                             state_d = S_DWELL;
         end
         S_DWELL: begin
            if (abort_i)                           state_d = S_IDLE;
            else if (dwell_q == DCW'(DWELL - 1))   state_d = S_STEP;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // A step aborted in its own cycle still moves the position.
   always_comb begin
      pos_d   = pos_q;
      tgt_d   = tgt_q;
      rem_d   = rem_q;
      dir_d   = dir_q;
      dwell_d = dwell_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) tgt_d = target_i;
         end
         S_CALC: begin
            dir_d = calc_dir;
            rem_d = calc_rem;
         end
         S_STEP: begin
            pos_d   = dir_q ? pos_q + WIDTH'(1) : pos_q - WIDTH'(1);
            rem_d   = rem_q - WIDTH'(1);
            dwell_d = '0;
         end
         S_DWELL: begin
            dwell_d = dwell_q + DCW'(1);
         end
         default: ;
      endcase
      gray_d = pos_d ^ (pos_d >> 1);
   end

   always_comb begin
      busy_o     = (state_q == S_CALC) || (state_q == S_STEP) || (state_q == S_DWELL);
      done_o     = (state_q == S_DONE);
      step_o     = (state_q == S_STEP);
      dir_o      = dir_q;
      pos_gray_o = gray_q;
      pos_bin_o  = pos_q;
   end

endmodule

// File: tb/tb_gray_seek_ctrl.sv
// tb/tb_gray_seek_ctrl.sv - directed vector bench for gray_seek_ctrl (WIDTH=3, DWELL=2)
module tb_gray_seek_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, abort;
   logic [2:0] target;
   logic       busy, done, step, dir;
   logic [2:0] pos_gray, pos_bin;

   int nchecks = 0;
   int nerrors = 0;

   gray_seek_ctrl #(.WIDTH(3), .DWELL(2)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .abort_i    (abort),
      .target_i   (target),
      .busy_o     (busy),
      .done_o     (done),
      .step_o     (step),
      .dir_o      (dir),
      .pos_gray_o (pos_gray),
      .pos_bin_o  (pos_bin)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  tgt;
      logic        exp_dir;
      int          exp_n;
      int          exp_lat;
      logic [2:0]  exp_bin;
      logic [2:0]  exp_gray;
      logic [11:0] gseq;     // k-th gray code after step k at [3*k +: 3]
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input int act, input int exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Returns at the negedge just after the start edge (CALC cycle).
   task automatic seek_start(input logic [2:0] t, input logic with_abort);
      start  = 1'b1;
      target = t;
      abort  = with_abort;
      tick();
      start  = 1'b0;
      abort  = 1'b0;
   endtask

   task automatic run_seek(input int idx, input vec_t v);
      int         k;
      int         nsteps;
      int         nchg;
      int         last_step;
      logic [2:0] prev;
      prev      = pos_gray;
      nsteps    = 0;
      nchg      = 0;
      last_step = -1;
      seek_start(v.tgt, 1'b0);
      k = 0;
      while (k < 60) begin
         if (pos_gray !== prev) begin
            check($sformatf("v%0d gray_onebit", idx), $countones(pos_gray ^ prev), 1);
            if (nchg < 4)
               check($sformatf("v%0d gray_seq%0d", idx, nchg), int'(pos_gray), int'(v.gseq[3*nchg +: 3]));
            nchg++;
            prev = pos_gray;
         end
         if (step) begin
            if (last_step >= 0)
               check($sformatf("v%0d step_spacing", idx), k - last_step, 3);
            last_step = k;
            nsteps++;
         end
         if (done) break;
         tick();
         k++;
      end
      check($sformatf("v%0d latency", idx), k, v.exp_lat);
      check($sformatf("v%0d steps", idx), nsteps, v.exp_n);
      check($sformatf("v%0d gray_changes", idx), nchg, v.exp_n);
      check($sformatf("v%0d dir", idx), int'(dir), int'(v.exp_dir));
      check($sformatf("v%0d pos_bin", idx), int'(pos_bin), int'(v.exp_bin));
      check($sformatf("v%0d pos_gray", idx), int'(pos_gray), int'(v.exp_gray));
      tick();
      check($sformatf("v%0d done_pulse", idx), int'(done), 0);
      check($sformatf("v%0d idle_busy", idx), int'(busy), 0);
   endtask

   initial begin
      int k;
      int ndone;

      //          tgt     dir   n  lat bin     gray    gray sequence (last..first)
      vecs[0] = '{3'd3, 1'b1, 3, 8,  3'd3, 3'b010, {3'b000, 3'b010, 3'b011, 3'b001}};
      vecs[1] = '{3'd0, 1'b0, 3, 8,  3'd0, 3'b000, {3'b000, 3'b000, 3'b001, 3'b011}};
      vecs[2] = '{3'd5, 1'b0, 3, 8,  3'd5, 3'b111, {3'b000, 3'b111, 3'b101, 3'b100}};
      vecs[3] = '{3'd5, 1'b1, 0, 1,  3'd5, 3'b111, 12'h000};
      vecs[4] = '{3'd1, 1'b1, 4, 11, 3'd1, 3'b001, {3'b001, 3'b000, 3'b100, 3'b101}};
      vecs[5] = '{3'd0, 1'b0, 1, 2,  3'd0, 3'b000, {3'b000, 3'b000, 3'b000, 3'b000}};
      vecs[6] = '{3'd4, 1'b1, 4, 11, 3'd4, 3'b110, {3'b110, 3'b010, 3'b011, 3'b001}};
      vecs[7] = '{3'd7, 1'b1, 3, 8,  3'd7, 3'b100, {3'b000, 3'b100, 3'b101, 3'b111}};
      vecs[8] = '{3'd0, 1'b1, 1, 2,  3'd0, 3'b000, {3'b000, 3'b000, 3'b000, 3'b000}};

      rst    = 1'b1;
      start  = 1'b0;
      abort  = 1'b0;
      target = 3'd0;
      #12;
      check("rst pos_gray", int'(pos_gray), 0);
      check("rst pos_bin", int'(pos_bin), 0);
      check("rst busy", int'(busy), 0);
      check("rst done", int'(done), 0);
      check("rst step", int'(step), 0);
      check("rst dir", int'(dir), 1);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Asynchronous reset in the middle of the second step.
      seek_start(3'd3, 1'b0);
      k = 0;
      ndone = 0;
      while (k < 20 && ndone < 2) begin
         tick();
         k++;
         if (step) ndone++;
      end
      check("midrst reached_step2", ndone, 2);
      check("midrst pos_before", int'(pos_gray), 1);
      #2 rst = 1'b1;
      #1;
      check("midrst pos_gray", int'(pos_gray), 0);
      check("midrst pos_bin", int'(pos_bin), 0);
      check("midrst busy", int'(busy), 0);
      check("midrst step", int'(step), 0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) run_seek(i, vecs[i]);

      // Abort during the first DWELL: position holds at one step.
      seek_start(3'd3, 1'b0);
      tick();
      check("abort1 step", int'(step), 1);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort1 busy", int'(busy), 0);
      check("abort1 pos_gray", int'(pos_gray), 1);
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         if (done) ndone++;
         tick();
      end
      check("abort1 no_done", ndone, 0);

      // Second start while busy is ignored: 1 -> 3 takes two steps.
      seek_start(3'd3, 1'b0);
      tick();
      start  = 1'b1;
      target = 3'd6;
      tick();
      start  = 1'b0;
      k = 2;
      while (!done && k < 30) begin
         tick();
         k++;
      end
      check("busy_start latency", k, 5);
      check("busy_start pos_bin", int'(pos_bin), 3);
      tick();
      check("busy_start no_requeue", int'(busy), 0);

      // Abort coinciding with STEP: that step still lands.
      seek_start(3'd6, 1'b0);
      tick();
      check("abort2 step", int'(step), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort2 busy", int'(busy), 0);
      check("abort2 done", int'(done), 0);
      check("abort2 pos_bin", int'(pos_bin), 4);
      check("abort2 pos_gray", int'(pos_gray), 6);

      // Abort with start in IDLE: start wins, zero-length seek completes.
      seek_start(3'd4, 1'b1);
      check("abstart busy", int'(busy), 1);
      tick();
      check("abstart done", int'(done), 1);
      check("abstart pos_bin", int'(pos_bin), 4);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
